// File: rtl/spi_slave_shift_engine.sv
// SPI slave shift engine: oversamples sclk/cs/mosi0 on pclk, streams bytes through a
// one-entry tx holding buffer and a parallel rx port. All CPOL/CPHA modes, MSB/LSB-first.
module spi_slave_shift_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi0,
  output logic                  miso0,
  output logic                  miso0_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;

  state_t                 state_q;
  logic                   cpol_q, cpha_q, lsb_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [DATA_WIDTH-1:0]  rx_sr_q, tx_sr_q, buf_q, rx_data_q;
  logic                   buf_full_q, rx_valid_q, underrun_q, miso_q, oe_q;

  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                   in_xfer, sample_edge, shift_edge, cs_fall, load, wr_accept;
  logic                   lsb_d, miso_d;
  logic [DATA_WIDTH-1:0]  tx_sr_d, rx_sr_d;

  always_ff @(posedge pclk) begin
    if (!areset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi0};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_dly_q;
  assign sclk_fall  = ~sclk_s & sclk_dly_q;
  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;

  assign in_xfer     = (state_q == ACTIVE) & ~cs_s;
  assign sample_edge = in_xfer & (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = in_xfer & (cpha_q ? lead_edge : trail_edge);
  assign cs_fall     = (state_q == IDLE) & ~cs_s & cs_dly_q;

  // cpha=0 preloads on select; both modes reload on the shift edge seen at count 0
  assign load      = (cs_fall & ~cpha) | (shift_edge & (bit_cnt_q == '0));
  assign wr_accept = tx_valid & ~buf_full_q;
  assign lsb_d     = cs_fall ? lsb_first : lsb_q;

  always_comb begin
    tx_sr_d = tx_sr_q;
    if (load)            tx_sr_d = buf_full_q ? buf_q : '1;
    else if (shift_edge) tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  end

  assign miso_d  = lsb_d ? tx_sr_d[0] : tx_sr_d[DATA_WIDTH-1];
  assign rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                         : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};

  // state  | meaning
  // IDLE   | cs inactive, miso0 tristated, counter cleared, waiting for cs fall
  // ACTIVE | cs active, shifting on sclk edges per latched mode
  always_ff @(posedge pclk) begin
    if (!areset) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= load & ~buf_full_q;

      // a load in the same cycle as a write sees the buffer as it was before the write
      if (wr_accept)  buf_q      <= tx_data;
      if (load)       buf_full_q <= wr_accept;
      else if (wr_accept) buf_full_q <= 1'b1;

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          rx_sr_q   <= '0;
          oe_q      <= 1'b0;
          miso_q    <= 1'b0;
          if (cs_fall) begin
            state_q <= ACTIVE;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            oe_q    <= 1'b1;
            tx_sr_q <= tx_sr_d;
            miso_q  <= miso_d;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            oe_q      <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            tx_sr_q <= tx_sr_d;
            miso_q  <= miso_d;
            if (sample_edge) begin
              rx_sr_q <= rx_sr_d;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q  <= '0;
                rx_data_q  <= rx_sr_d;
                rx_valid_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso0       = miso_q;
  assign miso0_oe    = oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Bench for spi_slave_shift_engine: table of directed transfers, a mid-byte reset
// sequence and randomized transfers checked against a byte-level buffer model.
`timescale 1ns/1ps
module tb_spi_slave_shift_engine;
  localparam int H = 6;

  logic       pclk = 1'b0, areset = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       sclk = 1'b0, cs = 1'b1, mosi0 = 1'b0;
  logic       miso0, miso0_oe, tx_ready, rx_valid, tx_underrun;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data;

  int n_checks = 0, n_fail = 0;

  always #5 pclk = ~pclk;

  spi_slave_shift_engine #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0), .miso0_oe(miso0_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
  );

  typedef struct {
    logic       pol, pha, lsb;
    int         nbytes;
    logic [7:0] d0, d1;
    logic       pre;
    logic [7:0] pre_byte;
    logic       refill;
    logic [7:0] rbyte;
    int         abort;
    string      name;
  } vec_t;

  // Model: holding buffer contents and the sequence of bytes the engine should load.
  logic [7:0] mbuf_q[$];
  logic [7:0] loads[$];
  int         exp_ur;

  logic [7:0] rxq[$];
  int         ur_cnt = 0;

  always @(negedge pclk) begin
    if (rx_valid)    rxq.push_back(rx_data);
    if (tx_underrun) ur_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  function automatic logic [7:0] model_load();
    if (mbuf_q.size() == 0) begin
      exp_ur++;
      return 8'hFF;
    end
    return mbuf_q.pop_front();
  endfunction

  task automatic write_tx(input logic [7:0] b);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 50) begin cyc(1); t++; end
    if (tx_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_tx timeout: tx_ready=%b, expected 1", tx_ready);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
      mbuf_q.push_back(b);
    end
  endtask

  task automatic spi_bit(input logic pol, input logic pha, input logic b, output logic m);
    if (!pha) begin
      mosi0 = b; cyc(H); m = miso0; sclk = ~pol; cyc(H); sclk = pol;
    end else begin
      sclk = ~pol; mosi0 = b; cyc(H); m = miso0; sclk = pol; cyc(H);
    end
  endtask

  task automatic xfer(input vec_t v);
    logic [7:0] cap [2];
    logic       m;
    int         nbits, nfull, rx_base, ur_base;
    loads.delete();
    exp_ur  = 0;
    rx_base = rxq.size();
    ur_base = ur_cnt;
    cpol = v.pol; cpha = v.pha; lsb_first = v.lsb; sclk = v.pol;
    cyc(4);
    if (v.pre && mbuf_q.size() == 0) write_tx(v.pre_byte);
    cyc(2);
    cs = 1'b0;
    if (!v.pha) loads.push_back(model_load());
    cyc(H);
    check({v.name, " oe_active"}, 32'(miso0_oe), 32'd1);
    {cpol, cpha, lsb_first} = 3'($urandom);
    nbits = (v.abort != 0) ? v.abort : 8 * v.nbytes;
    for (int i = 0; i < nbits; i++) begin
      int         k  = i / 8;
      int         j  = i % 8;
      int         bi = v.lsb ? j : 7 - j;
      logic [7:0] d  = (k == 0) ? v.d0 : v.d1;
      if (v.refill && i == 3) write_tx(v.rbyte);
      if (v.pha && j == 0) loads.push_back(model_load());
      spi_bit(v.pol, v.pha, d[bi], m);
      cap[k][bi] = m;
      if (!v.pha && j == 7) loads.push_back(model_load());
    end
    cyc(H);
    cs = 1'b1;
    cyc(8);
    nfull = (v.abort != 0) ? 0 : v.nbytes;
    check({v.name, " rx_count"}, 32'(rxq.size() - rx_base), 32'(nfull));
    for (int k = 0; k < nfull; k++) begin
      logic [7:0] d = (k == 0) ? v.d0 : v.d1;
      if (rxq.size() > rx_base + k) check({v.name, " rx_data"}, 32'(rxq[rx_base + k]), 32'(d));
      check({v.name, " miso_byte"}, 32'(cap[k]), 32'(loads[k]));
    end
    check({v.name, " underruns"}, 32'(ur_cnt - ur_base), 32'(exp_ur));
    check({v.name, " tx_ready"}, 32'(tx_ready), 32'(mbuf_q.size() == 0));
    check({v.name, " oe_idle"}, 32'(miso0_oe), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " miso0"},       32'(miso0),       32'd0);
    check({tag, " miso0_oe"},    32'(miso0_oe),    32'd0);
    check({tag, " tx_ready"},    32'(tx_ready),    32'd1);
    check({tag, " rx_data"},     32'(rx_data),     32'd0);
    check({tag, " rx_valid"},    32'(rx_valid),    32'd0);
    check({tag, " tx_underrun"}, 32'(tx_underrun), 32'd0);
  endtask

  vec_t tbl [7];

  initial begin
    logic m;
    vec_t r;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00, 0, "mode0_msb"};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1, 8'h0F, 8'h00, 1'b1, 8'h81, 1'b0, 8'h00, 0, "mode3_lsb"};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2, 8'h12, 8'h34, 1'b1, 8'h9A, 1'b1, 8'h56, 0, "mode1_2byte"};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2, 8'h12, 8'h34, 1'b1, 8'h9A, 1'b1, 8'h56, 0, "mode2_2byte"};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 0, "underrun"};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 5, "abort5"};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1, 8'hC3, 8'h00, 1'b1, 8'h6E, 1'b0, 8'h00, 0, "after_abort"};

    cyc(5);
    areset = 1'b1;
    check_reset_vals("por");
    cyc(5);

    for (int t = 0; t < 7; t++) xfer(tbl[t]);

    // reset three bits into a mode-0 byte, with a byte waiting in the buffer
    loads.delete();
    exp_ur = 0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk = 1'b0;
    cyc(4);
    cs = 1'b0;
    void'(model_load());
    cyc(H);
    write_tx(8'h42);
    check("rst_seq tx_ready_low", 32'(tx_ready), 32'd0);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, 1'b1, m);
    areset = 1'b0;
    cyc(1);
    areset = 1'b1;
    check_reset_vals("midreset");
    mbuf_q.delete();
    cs = 1'b1;
    cyc(8);
    r = '{1'b0, 1'b0, 1'b0, 1, 8'h99, 8'h00, 1'b1, 8'hE7, 1'b0, 8'h00, 0, "post_reset"};
    xfer(r);

    for (int n = 0; n < 24; n++) begin
      r.pol      = 1'($urandom);
      r.pha      = 1'($urandom);
      r.lsb      = 1'($urandom);
      r.nbytes   = int'($urandom_range(1, 2));
      r.d0       = 8'($urandom);
      r.d1       = 8'($urandom);
      r.pre      = 1'($urandom);
      r.pre_byte = 8'($urandom);
      r.refill   = 1'($urandom);
      r.rbyte    = 8'($urandom);
      r.abort    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      r.name     = $sformatf("rand%0d", n);
      xfer(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
